// File: rtl/ne_window_ctrl_if.sv
// Sample-in and window-result streams of ne_window_ctrl, each with valid/ready.
// The slave modport is the controller's side; master is the producer/consumer side.
interface ne_window_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = DATA_WIDTH + 9
);
  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic signed [ACC_WIDTH-1:0]  win_sum;
  logic                         win_flag;
  logic                         win_valid;
  logic                         win_ready;

  modport slave (
    input  s_valid, s_data, win_ready,
    output s_ready, win_sum, win_flag, win_valid
  );

  modport master (
    output s_valid, s_data, win_ready,
    input  s_ready, win_sum, win_flag, win_valid
  );
endinterface

// File: rtl/ne_window_ctrl.sv
// Primes the NE unit, then sums WIN_LEN NE outputs per window with saturation and a threshold flag.
// Result is registered one cycle after the last sample; a full result buffer drops new results (sticky overrun).
module ne_window_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WIN_LEN    = 256,
  parameter int PRIME_CNT  = 2,
  parameter int ACC_WIDTH  = DATA_WIDTH + 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic signed [ACC_WIDTH-1:0]  thr,
  ne_window_ctrl_if.slave              bus,
  output logic                         ne_en,
  output logic signed [DATA_WIDTH-1:0] ne_din,
  input  logic signed [DATA_WIDTH:0]   ne_dout,
  input  logic                         ne_valid,
  output logic                         busy,
  output logic                         overflow,
  output logic                         overrun
);

  localparam int CNT_W  = $clog2(WIN_LEN);
  localparam int PCNT_W = (PRIME_CNT < 2) ? 1 : $clog2(PRIME_CNT);
  localparam int PL     = (PRIME_CNT > 0) ? PRIME_CNT - 1 : 0;
  localparam logic [CNT_W-1:0]  WIN_LAST   = CNT_W'(WIN_LEN - 1);
  localparam logic [PCNT_W-1:0] PRIME_LAST = PCNT_W'(PL);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] thr_q, thr_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PCNT_W-1:0]           pcnt_q, pcnt_d;
  logic                        flag_q, flag_d;
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;
  logic                        ovr_q, ovr_d;

  logic signed [ACC_WIDTH:0]   add_full;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        sat;
  logic                        active;

  // One guard bit catches signed overflow: top two bits of the sum disagree.
  always_comb begin
    add_full = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH-DATA_WIDTH){ne_dout[DATA_WIDTH]}}, ne_dout};
    sat      = add_full[ACC_WIDTH] != add_full[ACC_WIDTH-1];
    acc_next = add_full[ACC_WIDTH-1:0];
    if (sat) acc_next = add_full[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    flag_d  = flag_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;

    if (valid_q && bus.win_ready) valid_d = 1'b0;

    if (stop) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            thr_d   = thr;
            acc_d   = '0;
            cnt_d   = '0;
            pcnt_d  = '0;
            state_d = (PRIME_CNT == 0) ? RUN : PRIME;
          end
        end
        PRIME: begin
          if (ne_valid) begin
            if (pcnt_q == PRIME_LAST) state_d = RUN;
            else                      pcnt_d  = pcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (ne_valid) begin
            if (sat) ovf_d = 1'b1;
            if (cnt_q == WIN_LAST) begin
              acc_d = '0;
              cnt_d = '0;
              // A result still waiting for its consumer wins over the new one.
              if (valid_q && !bus.win_ready) begin
                ovr_d = 1'b1;
              end else begin
                sum_d   = acc_next;
                flag_d  = acc_next >= thr_q;
                valid_d = 1'b1;
              end
            end else begin
              acc_d = acc_next;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      thr_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign active        = state_q != IDLE;
  assign busy          = active;
  assign bus.s_ready   = active;
  assign ne_en         = bus.s_valid & active;
  // Gated by reset so the NE input is quiet while reset is held.
  assign ne_din        = rst ? bus.s_data : '0;
  assign bus.win_sum   = sum_q;
  assign bus.win_flag  = flag_q;
  assign bus.win_valid = valid_q;
  assign overflow      = ovf_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_ne_window_ctrl.sv
// Directed bench for ne_window_ctrl: stimulus pushes expected window results, a monitor pops them on handshake.
module tb_ne_window_ctrl;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic signed [8:0]  thr;
  logic               ne_en;
  logic signed [7:0]  ne_din;
  logic signed [8:0]  ne_dout;
  logic               ne_valid;
  logic               busy;
  logic               overflow;
  logic               overrun;

  ne_window_ctrl_if #(.DATA_WIDTH(8), .ACC_WIDTH(9)) bus ();

  ne_window_ctrl #(
    .DATA_WIDTH(8),
    .WIN_LEN   (4),
    .PRIME_CNT (2),
    .ACC_WIDTH (9)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .thr     (thr),
    .bus     (bus),
    .ne_en   (ne_en),
    .ne_din  (ne_din),
    .ne_dout (ne_dout),
    .ne_valid(ne_valid),
    .busy    (busy),
    .overflow(overflow),
    .overrun (overrun)
  );

  typedef struct {
    int sum;
    int flag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: one comparison set per accepted result.
  always @(negedge clk) begin
    if (rst && bus.win_valid && bus.win_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got sum %0d with no expected result queued", int'(bus.win_sum));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_sum", int'(bus.win_sum), e.sum);
        chk("sb_flag", int'(bus.win_flag), e.flag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ne(input int v);
    ne_dout  = 9'(v);
    ne_valid = 1'b1;
    tick();
    ne_valid = 1'b0;
    ne_dout  = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic expect_win(input int sum, input int flag);
    exp_t e;
    e.sum  = sum;
    e.flag = flag;
    exp_q.push_back(e);
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, "_s_ready"},   int'(bus.s_ready),   0);
    chk({tag, "_ne_en"},     int'(ne_en),         0);
    chk({tag, "_ne_din"},    int'(ne_din),        0);
    chk({tag, "_win_sum"},   int'(bus.win_sum),   0);
    chk({tag, "_win_flag"},  int'(bus.win_flag),  0);
    chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_busy"},      int'(busy),          0);
    chk({tag, "_overflow"},  int'(overflow),      0);
    chk({tag, "_overrun"},   int'(overrun),       0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    thr           = '0;
    ne_valid      = 1'b0;
    ne_dout       = '0;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'sh11;
    bus.win_ready = 1'b1;
    #3;
    check_outs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("idle_s_ready", int'(bus.s_ready), 0);
    chk("idle_ne_en", int'(ne_en), 0);

    // Nominal: two primed outputs discarded, then 1+2+3+4 = 10 >= thr 10.
    thr = 9'sd10;
    pulse_start();
    chk("prime_busy", int'(busy), 1);
    chk("prime_s_ready", int'(bus.s_ready), 1);
    chk("prime_ne_en", int'(ne_en), 1);
    bus.s_data = -8'sd3;
    #1;
    chk("ne_din_pass", int'(ne_din), -3);
    send_ne(5);
    send_ne(5);
    expect_win(10, 1);
    send_ne(1);
    send_ne(2);
    send_ne(3);
    chk("nominal_not_early", int'(bus.win_valid), 0);
    send_ne(4);
    chk("nominal_latency", int'(bus.win_valid), 1);
    chk("nominal_no_ovf", int'(overflow), 0);
    tick();

    // Saturation: 255 + 255 clips at the 9-bit signed maximum.
    pulse_stop();
    thr = 9'sd0;
    pulse_start();
    send_ne(0);
    send_ne(0);
    expect_win(255, 1);
    repeat (4) send_ne(255);
    chk("sat_overflow", int'(overflow), 1);
    repeat (3) tick();
    chk("sat_overflow_sticky", int'(overflow), 1);

    // Overrun: first window held while unread, second window dropped.
    pulse_stop();
    thr = 9'sd5;
    bus.win_ready = 1'b0;
    pulse_start();
    send_ne(0);
    send_ne(0);
    expect_win(4, 0);
    repeat (4) send_ne(1);
    chk("ovr_no_early", int'(overrun), 0);
    repeat (4) send_ne(2);
    chk("ovr_valid_held", int'(bus.win_valid), 1);
    chk("ovr_sum_held", int'(bus.win_sum), 4);
    chk("ovr_flag", int'(overrun), 1);
    bus.win_ready = 1'b1;
    tick();
    chk("ovr_valid_drop", int'(bus.win_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);

    // Stop mid-window, restart: partial sum and prime state must be discarded.
    pulse_stop();
    thr = 9'sd0;
    pulse_start();
    send_ne(7);
    send_ne(7);
    send_ne(3);
    send_ne(3);
    pulse_stop();
    chk("stop_busy", int'(busy), 0);
    chk("stop_s_ready", int'(bus.s_ready), 0);
    send_ne(50);
    pulse_start();
    send_ne(9);
    send_ne(9);
    expect_win(4, 1);
    repeat (4) send_ne(1);
    tick();

    // Start and stop together in IDLE: stop wins.
    pulse_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_s_ready", int'(bus.s_ready), 0);
    tick();
    chk("startstop_busy_later", int'(busy), 0);

    // Reset in RUN with a pending result, then a fresh run must prime again.
    thr = 9'sd3;
    bus.win_ready = 1'b0;
    pulse_start();
    send_ne(0);
    send_ne(0);
    repeat (4) send_ne(1);
    chk("rstrun_valid_before", int'(bus.win_valid), 1);
    bus.s_data = 8'sh55;
    #2;
    rst = 1'b0;
    #1;
    check_outs_zero("rstrun");
    tick();
    rst = 1'b1;
    bus.win_ready = 1'b1;
    tick();
    pulse_start();
    chk("reprime_busy", int'(busy), 1);
    send_ne(100);
    send_ne(100);
    expect_win(4, 1);
    repeat (4) send_ne(1);
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ne_window_ctrl.md
NE_WINDOW_CTRL -- requirements
Module: ne_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input sample width.
REQ-002 SHALL have parameter WIN_LEN, default 256, NE outputs summed per window, range 2..65536.
REQ-003 SHALL have parameter PRIME_CNT, default 2, NE outputs discarded after each start.
REQ-004 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+9, accumulator width, at least DATA_WIDTH+1.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a run.
REQ-008 SHALL have port stop, input, 1, one-cycle pulse that aborts a run.
REQ-009 SHALL have port thr, input, ACC_WIDTH signed, detection threshold.
REQ-010 SHALL have ports s_valid (in, 1), s_ready (out, 1) and s_data (in, DATA_WIDTH signed), the sample stream.
REQ-011 SHALL have ports ne_en (out, 1) and ne_din (out, DATA_WIDTH signed), driving ne_comp_unit en/din.
REQ-012 SHALL have ports ne_dout (in, DATA_WIDTH+1 signed) and ne_valid (in, 1), from ne_comp_unit dout/data_valid.
REQ-013 SHALL have ports win_sum (out, ACC_WIDTH signed), win_flag (out, 1), win_valid (out, 1) and win_ready (in, 1), the result stream.
REQ-014 SHALL have ports busy (out, 1), overflow (out, 1, sticky) and overrun (out, 1, sticky).

Function
REQ-015 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-016 SHALL move IDLE->PRIME on start, capturing thr into an internal register and clearing accumulator, window counter and prime counter.
REQ-017 SHALL ignore start outside IDLE; stop in any state SHALL force IDLE next cycle; stop with start in the same cycle: stop wins.
REQ-018 SHALL, in PRIME, count ne_valid pulses and discard ne_dout; after the PRIME_CNT-th pulse go to RUN. PRIME_CNT=0 SHALL go directly IDLE->RUN.
REQ-019 SHALL drive s_ready=1 in PRIME/RUN and 0 in IDLE; ne_en=s_valid&s_ready and ne_din=s_data combinationally.
REQ-020 SHALL, in RUN, on each ne_valid, add sign-extended ne_dout to the accumulator and increment the window counter.
REQ-021 SHALL saturate accumulation at signed ACC_WIDTH max/min and set overflow on any saturation; overflow clears only on reset.
REQ-022 SHALL, on the WIN_LEN-th accumulation, present the final sum (including that sample) next cycle: win_sum=sum, win_flag=(sum>=captured thr, signed), win_valid=1.
REQ-023 SHALL clear the accumulator and counter in that same update and continue in RUN with no gap (continuous windows, no re-prime).
REQ-024 SHALL hold win_sum/win_flag/win_valid stable until win_valid&win_ready; win_valid then drops next cycle unless a new result loads.
REQ-025 SHALL, if a new result completes while win_valid=1 and win_ready=0, drop the new result, keep the old one and set sticky overrun.
REQ-026 SHALL load the new result when completion coincides with win_valid&win_ready; win_valid stays 1.
REQ-027 SHALL ignore ne_valid in IDLE; stop SHALL discard a partial window without touching the result buffer.
REQ-028 SHALL drive busy=1 when state is not IDLE.

Reset
REQ-029 SHALL, while rst=0, immediately force IDLE and all outputs to 0 (s_ready, ne_en, ne_din, win_sum, win_flag, win_valid, busy, overflow, overrun), including mid-window.
REQ-030 SHALL clear all counters, the accumulator and the captured threshold on reset.

Verification (DATA_WIDTH=8, WIN_LEN=4, PRIME_CNT=2, ACC_WIDTH=9 unless noted)
REQ-031 SHALL cover nominal operation: thr=10, start, ne_dout 5,5 (primed), then 1,2,3,4 -> win_sum=10, win_flag=1, win_valid one cycle after the 4th ne_valid.
REQ-032 SHALL cover saturation: thr=0, ne_dout=255 four times in RUN -> win_sum=255, overflow=1 and remains 1.
REQ-033 SHALL cover overrun: win_ready=0, two windows of 1,1,1,1 then 2,2,2,2 -> win_sum=4 held, overrun=1.
REQ-034 SHALL cover stop/restart: stop after 2 RUN samples, then start, ne_dout 9,9,1,1,1,1 -> win_sum=4.
REQ-035 SHALL cover start and stop together in IDLE -> busy stays 0 and s_ready stays 0.
REQ-036 SHALL cover reset during RUN with win_valid=1 -> all outputs 0 asynchronously; a subsequent start primes again.
